pw_ref_ctrl: RTL and testbench

Upstream control stage for the PWM block. Turns two raw push-buttons into a saturating 4-bit duty reference and produces the divided PWM count clock. The PWM block consumes `f_media_o` as its count clock and `ref_o` as its comparison reference. `ref_o` changes only at a PWM period boundary, so a duty update never produces a truncated or glitched pulse. A shadow 4-bit phase counter tracks the PWM block's counter to locate that boundary.

---
 rtl/pw_ref_ctrl.sv | 117 +++++++++++
 tb/tb_pw_ref_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pw_ref_ctrl.sv
// pw_ref_ctrl: debounced up/down duty reference with period-aligned commit and PWM count clock
module pw_ref_ctrl #(
   parameter int         DIV_HALF   = 25000,
   parameter int         DEB_CYCLES = 500000,
   parameter logic [3:0] REF_INIT   = 4'd8
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic       btn_up_i,
   input  logic       btn_dn_i,
   output logic       f_media_o,
   output logic [3:0] ref_o,
   output logic [3:0] ref_pending_o,
   output logic [3:0] phase_o,
   output logic       period_start_o
);
   localparam int DW = $clog2(DIV_HALF + 1);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV_HALF - 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

   logic [1:0]    w_btn;
   logic [1:0]    r_s1;
   logic [1:0]    r_s2;
   logic [1:0]    w_pls;
   logic [3:0]    r_pend;
   logic [3:0]    r_ref;
   logic [3:0]    r_ph;
   logic [DW-1:0] r_div;
   logic          r_f;
   logic          r_ps;
   logic          w_tick;
   logic          w_rise;
   logic          w_wrap;

   assign w_btn  = {btn_dn_i, btn_up_i};
   assign w_tick = r_div == DIV_MAX;
   assign w_rise = w_tick && !r_f;
   assign w_wrap = w_rise && r_ph == 4'hF;

   // two-flop synchronizer for both raw buttons
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_s1 <= 2'b00;
         r_s2 <= 2'b00;
      end else begin
         r_s1 <= w_btn;
         r_s2 <= r_s1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_deb
         logic [CW-1:0] r_cnt;
         logic          r_deb;
         logic          r_pls;
         assign w_pls[g] = r_pls;
         // debounce: flip after DEB_CYCLES stable mismatches, pulse on the 0->1 flip
         always_ff @(posedge clk_i or negedge reset) begin
            if (!reset) begin
               r_cnt <= '0;
               r_deb <= 1'b0;
               r_pls <= 1'b0;
            end else begin
               r_pls <= 1'b0;
               if (r_s2[g] == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == DEB_MAX) begin
                  r_cnt <= '0;
                  r_deb <= ~r_deb;
                  r_pls <= ~r_deb;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

   // saturating pending reference; simultaneous up and down cancel
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) r_pend <= REF_INIT;
      else if (w_pls == 2'b01 && r_pend != 4'hF) r_pend <= r_pend + 4'd1;
      else if (w_pls == 2'b10 && r_pend != 4'h0) r_pend <= r_pend - 4'd1;
   end

   // half-period divider producing the PWM count clock
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_div <= '0;
         r_f   <= 1'b0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         r_f   <= w_tick ? ~r_f : r_f;
      end
   end

   // shadow phase of the PWM counter; commit the pending value on its wrap
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_ph  <= 4'd0;
         r_ref <= REF_INIT;
         r_ps  <= 1'b0;
      end else begin
         r_ph  <= w_rise ? r_ph + 4'd1 : r_ph;
         r_ref <= w_wrap ? r_pend : r_ref;
         r_ps  <= w_wrap;
      end
   end

   assign f_media_o      = r_f;
   assign ref_o          = r_ref;
   assign ref_pending_o  = r_pend;
   assign phase_o        = r_ph;
   assign period_start_o = r_ps;
endmodule

// File: tb/tb_pw_ref_ctrl.sv
// tb_pw_ref_ctrl: press table with scoreboarded pending updates and closed-form clock/phase/commit checks
module tb_pw_ref_ctrl;
   localparam int DH = 2;
   localparam int DB = 4;

   logic       clk_i = 1'b0;
   logic       reset = 1'b1;
   logic       btn_up_i = 1'b0;
   logic       btn_dn_i = 1'b0;
   logic       f_media_o;
   logic [3:0] ref_o;
   logic [3:0] ref_pending_o;
   logic [3:0] phase_o;
   logic       period_start_o;

   pw_ref_ctrl #(.DIV_HALF(DH), .DEB_CYCLES(DB), .REF_INIT(4'd8)) dut (
      .clk_i(clk_i), .reset(reset), .btn_up_i(btn_up_i), .btn_dn_i(btn_dn_i),
      .f_media_o(f_media_o), .ref_o(ref_o), .ref_pending_o(ref_pending_o),
      .phase_o(phase_o), .period_start_o(period_start_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {int e; logic [3:0] v;} sb_t;
   typedef struct {logic up; logic dn; int hold; logic [3:0] x;} vec_t;

   sb_t        sb[$];
   sb_t        top;
   vec_t       tbl[$];
   int         ec;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [3:0] exp_pend = 4'd8;
   logic [3:0] exp_ref = 4'd8;
   logic       wrap;

   task automatic chk(input string n, input int a, input int x);
      n_chk++;
      if (a == x) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at edge %0d", n, a, x, ec);
   endtask

   task automatic reset_chk(input string n);
      chk({n, "_f_media"}, f_media_o, 0);
      chk({n, "_ref"}, ref_o, 8);
      chk({n, "_ref_pending"}, ref_pending_o, 8);
      chk({n, "_phase"}, phase_o, 0);
      chk({n, "_period_start"}, period_start_o, 0);
   endtask

   task automatic press(input logic up, input logic dn, input int hold, input logic [3:0] x);
      sb_t t;
      t.e = ec + DB + 3;
      t.v = x;
      sb.push_back(t);
      btn_up_i = up;
      btn_dn_i = dn;
      repeat (hold) @(negedge clk_i);
      btn_up_i = 1'b0;
      btn_dn_i = 1'b0;
      repeat (12) @(negedge clk_i);
   endtask

   always @(posedge clk_i or negedge reset)
      if (!reset) ec <= 0;
      else ec <= ec + 1;

   always @(negedge clk_i) begin
      if (reset && ec > 0) begin
         wrap = ec >= 31 * DH && (ec - 31 * DH) % (32 * DH) == 0;
         if (wrap) exp_ref = exp_pend;
         if (sb.size() > 0 && sb[0].e == ec) begin
            top = sb.pop_front();
            exp_pend = top.v;
         end
         chk("f_media", f_media_o, (ec / DH) % 2);
         chk("phase", phase_o, ((ec + DH) / (2 * DH)) % 16);
         chk("period_start", period_start_o, int'(wrap));
         chk("ref_pending", ref_pending_o, exp_pend);
         chk("ref", ref_o, exp_ref);
      end
   end

   initial begin
      tbl.push_back('{1'b1, 1'b0, 10, 4'd9});
      tbl.push_back('{1'b1, 1'b0, 3, 4'd9});
      for (int i = 0; i < 7; i++) tbl.push_back('{1'b1, 1'b0, 10, (i < 5) ? 4'(10 + i) : 4'd15});
      for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 1'b1, 10, (i < 15) ? 4'(14 - i) : 4'd0});
      tbl.push_back('{1'b1, 1'b0, 10, 4'd1});
      tbl.push_back('{1'b1, 1'b1, 10, 4'd1});
      #1 reset = 1'b0;
      #1 reset_chk("por");
      repeat (3) @(negedge clk_i);
      reset = 1'b1;
      repeat (200) @(negedge clk_i);
      for (int i = 0; i < tbl.size(); i++) press(tbl[i].up, tbl[i].dn, tbl[i].hold, tbl[i].x);
      for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 10, 4'(2 + i));
      for (int i = 0; i < 200 && !(ec > 31 * DH && (ec - 31 * DH) % (32 * DH) == 1); i++) @(negedge clk_i);
      press(1'b1, 1'b0, 10, 4'd11);
      press(1'b1, 1'b0, 10, 4'd12);
      chk("pre_reset_ref", ref_o, 10);
      chk("pre_reset_pending", ref_pending_o, 12);
      #2 reset = 1'b0;
      #1 reset_chk("mid");
      sb.delete();
      exp_pend = 4'd8;
      exp_ref = 4'd8;
      repeat (2) @(negedge clk_i);
      reset = 1'b1;
      repeat (130) @(negedge clk_i);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
